// File: rtl/pc_pkg.sv
// Shared FSM state encoding and fault cause constants for the PC source register.
package pc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } pc_state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_BADSEL   = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

endpackage

// File: rtl/pc_src_mux.sv
// PC source selector: picks one WIDTH-bit slice of the flattened source bus.
// Unpopulated select values return zero with sel_valid_o low, so every select
// value has a defined output.
module pc_src_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 7,
  parameter int unsigned SELW  = 3
) (
  input  logic [SELW-1:0]       sel_i,
  input  logic [NSRC*WIDTH-1:0] src_bus_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  sel_valid_o
);

  // Compare the select against each populated index; no match means invalid.
  always_comb begin
    data_o      = '0;
    sel_valid_o = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (sel_i == SELW'(i)) begin
        data_o      = src_bus_i[i*WIDTH +: WIDTH];
        sel_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_src_reg.sv
// Program counter register with selectable load source and a two-state
// RUN/TRAP fault handler. Optional target alignment checking is enabled by
// defining PC_ALIGN_CHECK_EN.
module pc_src_reg
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      NSRC     = 7,
  parameter int unsigned      SELW     = 3,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC  = 'h0000_00FD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_write,
  input  logic [SELW-1:0]       pc_sel,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  output logic [WIDTH-1:0]      pc_out,
  output logic [WIDTH-1:0]      epc_out,
  output logic                  exc_flag,
  output logic [1:0]            exc_cause,
  output logic                  busy
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             flag_q, flag_d;
  logic [1:0]       cause_q, cause_d;

  logic [WIDTH-1:0] target;
  logic             sel_valid;
  logic             misaligned;

  pc_src_mux #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_mux (
    .sel_i       (pc_sel),
    .src_bus_i   (src_bus),
    .data_o      (target),
    .sel_valid_o (sel_valid)
  );

  // Alignment fault only exists when the check is built in.
  always_comb begin
`ifdef PC_ALIGN_CHECK_EN
    misaligned = sel_valid && (target[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end

  // Next-state and register update logic; invalid select outranks misalignment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    flag_d  = 1'b0;
    cause_d = cause_q;
    unique case (state_q)
      RUN: begin
        if (pc_write) begin
          if (!sel_valid) begin
            state_d = TRAP;
            epc_d   = pc_q;
            flag_d  = 1'b1;
            cause_d = CAUSE_BADSEL;
          end else if (misaligned) begin
            state_d = TRAP;
            epc_d   = pc_q;
            flag_d  = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            pc_d = target;
          end
        end
      end
      TRAP: begin
        state_d = RUN;
        pc_d    = EXC_VEC;
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      flag_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      flag_q  <= flag_d;
      cause_q <= cause_d;
    end
  end

  assign pc_out    = pc_q;
  assign epc_out   = epc_q;
  assign exc_flag  = flag_q;
  assign exc_cause = cause_q;
  assign busy      = (state_q == TRAP);

endmodule

// File: tb/tb_pc_src_reg.sv
// Scoreboard bench for pc_src_reg: each driven cycle pushes the hand-computed
// register contents expected after the next edge; a monitor pops and compares.
// Expectations follow PC_ALIGN_CHECK_EN when the same macro is defined here.
module tb_pc_src_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSRC  = 7;
  localparam int unsigned SELW  = 3;
  localparam logic [31:0] EXC   = 32'h0000_00FD;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        flag;
    logic [1:0]  cause;
    logic        busy;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  pc_write;
  logic [SELW-1:0]       pc_sel;
  logic [NSRC*WIDTH-1:0] src_bus;
  logic [WIDTH-1:0]      pc_out;
  logic [WIDTH-1:0]      epc_out;
  logic                  exc_flag;
  logic [1:0]            exc_cause;
  logic                  busy;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  pc_src_reg #(
    .WIDTH    (WIDTH),
    .NSRC     (NSRC),
    .SELW     (SELW),
    .RESET_PC (32'h0),
    .EXC_VEC  (EXC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .src_bus   (src_bus),
    .pc_out    (pc_out),
    .epc_out   (epc_out),
    .exc_flag  (exc_flag),
    .exc_cause (exc_cause),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are registered, so every edge presents a new response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (pc_out !== e.pc) begin
          errors++;
          $display("FAIL pc_out: got %h expected %h at %0t", pc_out, e.pc, $time);
        end
        checks++;
        if (epc_out !== e.epc) begin
          errors++;
          $display("FAIL epc_out: got %h expected %h at %0t", epc_out, e.epc, $time);
        end
        checks++;
        if (exc_flag !== e.flag) begin
          errors++;
          $display("FAIL exc_flag: got %b expected %b at %0t", exc_flag, e.flag, $time);
        end
        checks++;
        if (exc_cause !== e.cause) begin
          errors++;
          $display("FAIL exc_cause: got %b expected %b at %0t", exc_cause, e.cause, $time);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL busy: got %b expected %b at %0t", busy, e.busy, $time);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic wr, input logic [SELW-1:0] sel,
                      input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic e_flag, input logic [1:0] e_cause, input logic e_busy);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    pc_write = wr;
    pc_sel   = sel;
    e.pc = e_pc; e.epc = e_epc; e.flag = e_flag; e.cause = e_cause; e.busy = e_busy;
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] p6;
    logic [31:0] e6;
    logic [1:0]  c6;
    reset    = 1'b1;
    pc_write = 1'b0;
    pc_sel   = '0;
    src_bus  = {32'h0000_0013, 32'h0000_00C0, 32'h0000_0084, 32'h0000_0080,
                32'h0000_0042, 32'h0000_0040, 32'h0000_0010};

    step(1, 0, 0, 32'h0, 32'h0, 0, 2'b00, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0, 2'b00, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 32'h0, 0, 2'b00, 0);

    // Valid load, then invalid select fault and trap vector load.
    step(0, 1, 1, 32'h40, 32'h0, 0, 2'b00, 0);
    step(0, 0, 1, 32'h40, 32'h0, 0, 2'b00, 0);
    step(0, 1, 7, 32'h40, 32'h40, 1, 2'b01, 1);
    step(0, 1, 3, EXC,    32'h40, 0, 2'b01, 0);
    step(0, 0, 3, EXC,    32'h40, 0, 2'b01, 0);

`ifdef PC_ALIGN_CHECK_EN
    step(0, 1, 2, EXC, EXC, 1, 2'b10, 1);
    step(0, 0, 2, EXC, EXC, 0, 2'b10, 0);
    // Held request reloads every cycle; cause holds.
    step(0, 1, 3, 32'h80, EXC, 0, 2'b10, 0);
    step(0, 1, 3, 32'h80, EXC, 0, 2'b10, 0);
    step(0, 1, 4, 32'h84, EXC, 0, 2'b10, 0);
    step(0, 1, 5, 32'hC0, EXC, 0, 2'b10, 0);
`else
    step(0, 1, 2, 32'h42, 32'h40, 0, 2'b01, 0);
    step(0, 0, 2, 32'h42, 32'h40, 0, 2'b01, 0);
    step(0, 1, 3, 32'h80, 32'h40, 0, 2'b01, 0);
    step(0, 1, 3, 32'h80, 32'h40, 0, 2'b01, 0);
    step(0, 1, 4, 32'h84, 32'h40, 0, 2'b01, 0);
    step(0, 1, 5, 32'hC0, 32'h40, 0, 2'b01, 0);
`endif

    // Fault, then reset in the trap cycle: trap vector must never load.
    step(0, 1, 7, 32'hC0, 32'hC0, 1, 2'b01, 1);
    step(1, 1, 3, 32'h0,  32'h0,  0, 2'b00, 0);
    step(0, 0, 3, 32'h0,  32'h0,  0, 2'b00, 0);
    // Reset overrides a write request.
    step(1, 1, 1, 32'h0,  32'h0,  0, 2'b00, 0);
    step(0, 1, 0, 32'h10, 32'h0,  0, 2'b00, 0);

`ifdef PC_ALIGN_CHECK_EN
    step(0, 1, 6, 32'h10, 32'h10, 1, 2'b10, 1);
    step(0, 0, 6, EXC,    32'h10, 0, 2'b10, 0);
    p6 = EXC; e6 = 32'h10; c6 = 2'b10;
`else
    step(0, 1, 6, 32'h13, 32'h0,  0, 2'b00, 0);
    step(0, 0, 6, 32'h13, 32'h0,  0, 2'b00, 0);
    p6 = 32'h13; e6 = 32'h0; c6 = 2'b00;
`endif
    step(0, 0, 0, p6, e6, 0, c6, 0);

    // Held invalid request: fault, trap, then earliest re-fault.
    step(0, 1, 7, p6,  p6,  1, 2'b01, 1);
    step(0, 1, 7, EXC, p6,  0, 2'b01, 0);
    step(0, 1, 7, EXC, EXC, 1, 2'b01, 1);
    step(0, 0, 0, EXC, EXC, 0, 2'b01, 0);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_src_reg.md
PC_SRC_REG -- requirements
Module: pc_src_reg

Interface
REQ-001 Parameter WIDTH, default 32: PC and source data width in bits.
REQ-002 Parameter NSRC, default 7: number of populated PC sources, range 2..2**SELW.
REQ-003 Parameter SELW, default 3: select width.
REQ-004 Parameter RESET_PC, default 0: PC value after reset.
REQ-005 Parameter EXC_VEC, default 32'h0000_00FD: trap target loaded after a fault.
REQ-006 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port pc_write  input  1  request to load a new PC this cycle.
REQ-009 Port pc_sel  input  SELW  source index; source i occupies src_bus bits [i*WIDTH +: WIDTH].
REQ-010 Port src_bus  input  NSRC*WIDTH  flattened candidate PC values.
REQ-011 Port pc_out  output  WIDTH  registered current PC.
REQ-012 Port epc_out  output  WIDTH  registered PC captured at the last fault.
REQ-013 Port exc_flag  output  1  registered one-cycle fault pulse.
REQ-014 Port exc_cause  output  2  registered cause: 00 none, 01 invalid select, 10 misaligned target.
REQ-015 Port busy  output  1  high while in TRAP; pc_write is ignored.

Function
REQ-016 Two states: RUN, TRAP; the state register is the only FSM state.
REQ-017 RUN, pc_write=0: pc_out holds; exc_flag=0; exc_cause holds its last value.
REQ-018 RUN, pc_write=1, pc_sel<NSRC, target valid: pc_out <= selected source at the next edge (latency 1); exc_flag=0.
REQ-019 RUN, pc_write=1, pc_sel>=NSRC: fault with cause 01; pc_out holds; no source is read.
REQ-020 Every fault: at the next edge state <= TRAP, epc_out <= current pc_out, exc_flag <= 1, exc_cause <= cause.
REQ-021 TRAP: busy=1; at the next edge pc_out <= EXC_VEC, state <= RUN, exc_flag <= 0; pc_write and pc_sel are ignored.
REQ-022 Invalid select takes priority over misalignment when both apply.
REQ-023 Select decode is fully specified; no select value leaves pc_out undefined or inferring a latch.
REQ-024 No back-to-back faults: earliest next fault-accept is the first RUN cycle after TRAP.
REQ-025 pc_write is level-sampled each RUN cycle; a held request reloads every cycle.

Reset
REQ-026 reset=1 at an edge: pc_out=RESET_PC, epc_out=0, exc_flag=0, exc_cause=00, busy=0, state=RUN; overrides pc_write.
REQ-027 Reset during TRAP aborts the trap; EXC_VEC is not loaded.

Configuration
REQ-028 Macro PC_ALIGN_CHECK_EN defined: a selected target with bits [1:0] != 00 on pc_write in RUN is a fault with cause 10.
REQ-029 PC_ALIGN_CHECK_EN undefined: no alignment check; cause 10 is never produced; misaligned targets load normally.

Structure
REQ-030 Shared package pc_pkg holds state encoding (RUN, TRAP) and cause constants (CAUSE_NONE, CAUSE_BADSEL, CAUSE_MISALIGN).
REQ-031 One sub-module pc_src_mux (parametrised WIDTH/NSRC/SELW) outputs the selected value and a sel_valid flag; FSM and registers live in pc_src_reg.

Verification
REQ-032 Reset then idle: pc_out=0, epc_out=0, exc_cause=00, busy=0 for 5 cycles with pc_write=0.
REQ-033 Source 1=32'h0000_0040, pc_sel=1, pc_write=1 one cycle -> pc_out=32'h40 the next cycle, exc_flag stays 0.
REQ-034 pc_out=32'h40, pc_sel=7 (NSRC=7), pc_write=1 -> next cycle exc_flag=1, exc_cause=01, epc_out=32'h40, busy=1; following cycle pc_out=EXC_VEC, busy=0.
REQ-035 With PC_ALIGN_CHECK_EN, source 2=32'h0000_0042, pc_sel=2 -> exc_cause=10, epc_out=prior pc_out; without macro -> pc_out=32'h42, no fault.
REQ-036 Fault, then reset asserted in the TRAP cycle -> pc_out=RESET_PC, exc_flag=0, busy=0, epc_out=0; EXC_VEC never appears.
